mult_job_sequencer: RTL and testbench
=====================================

Name: mult_job_sequencer

Overview:
Front-end stage directly upstream of the Booth multiplier core (the controller plus its datapath).
- Accepts signed operand pairs over a valid/ready stream and buffers them in a small FIFO.
- Launches one multiplication at a time by driving start and holding the operands stable on the core's operand buses.
- Captures the product when the core reports done, and returns it on a valid/ready result stream with a timeout/error flag.

Parameters:
W, 8, operand width in bits; the product is 2*W bits.
DEPTH, 2, job FIFO entries; must be a power of two, at least 2.
TIMEOUT, 64, maximum cycles allowed in ACKW or RUNW before the job is aborted.

Ports:
clk  input  1  system clock; all state changes on its rising edge
rst  input  1  synchronous, active-high reset
in_valid  input  1  operand pair valid
in_ready  output  1  FIFO can accept a pair
in_x  input  W  multiplicand, two's complement
in_y  input  W  multiplier, two's complement
start  output  1  one-cycle launch pulse to the core
done  input  1  core done level; high when idle or finished, low while busy
core_x  output  W  multiplicand to the core
core_y  output  W  multiplier to the core
core_hi  input  W  product high half (core A register)
core_lo  input  W  product low half (core Y register)
res_valid  output  1  result slot full
res_ready  input  1  consumer accepts the result
res_prod  output  2W  captured product {core_hi, core_lo}
res_err  output  1  result was produced by a timeout abort
job_count  output  8  completed jobs; wraps 255 -> 0

Behaviour:
- Reset (synchronous): FIFO emptied, FSM to IDLE, start=0, res_valid=0, res_err=0, res_prod=0, core_x=core_y=0, job_count=0, timeout counter=0. A reset mid-job abandons the job with no result; the core shares the same rst.
- FIFO:
  - in_ready = !full.
  - A push on in_valid&&in_ready is visible at the head next cycle; there is no bypass.
  - A pop and a push in the same cycle are legal when not full.
  - A full FIFO ignores in_valid.
  - Pointers wrap modulo DEPTH.
- FSM states: IDLE, LAUNCH, ACKW, RUNW, RESP.
  - IDLE -> LAUNCH when the FIFO is non-empty && res_valid==0 && done==1. On that edge: pop the head and latch it into core_x/core_y.
  - LAUNCH: start=1 for exactly this cycle, then go to ACKW and clear the timeout counter.
  - ACKW: wait for done==0, which confirms the core accepted the job, then go to RUNW and clear the timeout counter.
  - RUNW: wait for done==1, then go to RESP. On that edge: res_prod <= {core_hi, core_lo}, res_err <= 0, res_valid <= 1, job_count increments.
  - RESP: one cycle, then back to IDLE. The earliest next launch is the cycle after res_valid clears.
  - Timeout: in ACKW or RUNW, the counter increments every cycle. When it reaches TIMEOUT-1 while still waiting, go to RESP with res_prod <= 0, res_err <= 1, res_valid <= 1. job_count still increments.
- core_x/core_y change only on the IDLE->LAUNCH edge; they are stable through RESP.
- Result handshake:
  - res_valid stays high until res_valid&&res_ready, then clears next cycle.
  - res_prod/res_err are stable while res_valid=1.
  - Back-pressure stalls launches; the FIFO keeps filling.
- start is never asserted outside LAUNCH, and never while res_valid=1.
- Throughput with a core latency of L cycles in RUNW: one job per L+4 cycles when res_ready is held high.

Decomposition:
- Shared package: FSM state encoding (3-bit, IDLE=0, LAUNCH=1, ACKW=2, RUNW=3, RESP=4), default W and TIMEOUT constants, and the product-width function 2*W.
- One sub-module: mult_job_fifo (synchronous FIFO, DEPTH x 2W, full/empty flags, push/pop).
- FSM, timeout counter and result register stay in the top module.

Test Plan:
1. Reset, then push (5,3). Behavioural core model: done low 6 cycles after start, then core_hi/core_lo=0x00/0x0F. Expect one start pulse 2 cycles after the push, then res_prod=16'h000F, res_err=0, job_count=1.
2. Push (-3,7) i.e. (8'hFD,8'h07); model returns 0xFF/0xEB. Expect res_prod=16'hFFEB, and core_x=8'hFD held constant from LAUNCH to RESP.
3. Back-to-back pushes of (1,2),(3,4),(5,6) with res_ready=0. Expect:
   - in_ready drops after 2 buffered jobs, and third-pair acceptance is delayed until the first job is popped;
   - exactly one launch, then no start pulse until res_ready=1.
   Then release res_ready and expect products 2, 12, 30 in order.
4. Model never drops done after start. Expect res_err=1, res_prod=0 exactly TIMEOUT cycles after entering ACKW, then the next queued job launches normally.
5. Assert rst for one cycle while in RUNW with 2 jobs queued. Expect next cycle: res_valid=0, in_ready=1, job_count=0, start=0, FIFO empty, no late capture when done later rises.
6. Run 256 jobs (0,0). Expect job_count wraps to 0 and every res_prod=0.

Source files
------------

// File: rtl/mult_job_sequencer_pkg.sv
// Shared types and defaults for the Booth multiplier job sequencer.
// Holds the FSM encoding, default sizing constants and the product-width helper.
package mult_job_sequencer_pkg;

    localparam int DEF_W       = 8;
    localparam int DEF_DEPTH   = 2;
    localparam int DEF_TIMEOUT = 64;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LAUNCH = 3'd1,
        ST_ACKW   = 3'd2,
        ST_RUNW   = 3'd3,
        ST_RESP   = 3'd4
    } state_e;

    function automatic int prod_width(input int w);
        return 2 * w;
    endfunction

endpackage

// File: rtl/mult_job_sequencer_if.sv
// Job-input stream, result stream and Booth core bus of the job sequencer.
// Streams (in_*, res_*): a beat transfers on a rising edge where valid && ready; valid and payload hold until then.
interface mult_job_sequencer_if #(
    parameter int W = 8
);

    logic           in_valid;
    logic           in_ready;
    logic [W-1:0]   in_x;
    logic [W-1:0]   in_y;

    logic           start;
    logic           done;
    logic [W-1:0]   core_x;
    logic [W-1:0]   core_y;
    logic [W-1:0]   core_hi;
    logic [W-1:0]   core_lo;

    logic           res_valid;
    logic           res_ready;
    logic [2*W-1:0] res_prod;
    logic           res_err;
    logic [7:0]     job_count;

    modport slave (
        input  in_valid, in_x, in_y, done, core_hi, core_lo, res_ready,
        output in_ready, start, core_x, core_y, res_valid, res_prod, res_err, job_count
    );

    modport master (
        output in_valid, in_x, in_y, done, core_hi, core_lo, res_ready,
        input  in_ready, start, core_x, core_y, res_valid, res_prod, res_err, job_count
    );

endinterface

// File: rtl/mult_job_sequencer_fifo.sv
// Synchronous job FIFO: DEPTH entries of DW bits, no bypass, push ignored when full.
// DEPTH must be a power of two so the pointers wrap by natural overflow.
module mult_job_fifo #(
    parameter int DW    = 16,
    parameter int DEPTH = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push_i,
    input  logic [DW-1:0] wdata_i,
    input  logic          pop_i,
    output logic [DW-1:0] rdata_o,
    output logic          full_o,
    output logic          empty_o
);

    localparam int AW = $clog2(DEPTH);

    logic [DW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wptr_q, wptr_d;
    logic [AW-1:0] rptr_q, rptr_d;
    logic [AW:0]   count_q, count_d;
    logic          do_push;
    logic          do_pop;

    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign rdata_o = mem_q[rptr_q];

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (do_push) wptr_d = wptr_q + AW'(1);
        if (do_pop)  rptr_d = rptr_q + AW'(1);
        if (do_push && !do_pop) count_d = count_q + (AW+1)'(1);
        if (!do_push && do_pop) count_d = count_q - (AW+1)'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    // Storage needs no reset: empty_o gates every read that matters.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wptr_q] <= wdata_i;
    end

endmodule

// File: rtl/mult_job_sequencer.sv
// Front-end for the Booth multiplier core: buffers operand pairs, launches one job at a time,
// captures the product (or a timeout abort) and offers it on the result stream.
module mult_job_sequencer
    import mult_job_sequencer_pkg::*;
#(
    parameter int W       = DEF_W,
    parameter int DEPTH   = DEF_DEPTH,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic                  clk,
    input  logic                  rst,
    mult_job_sequencer_if.slave   bus,
    output state_e                dbg_state_o
);

    localparam int PW = prod_width(W);
    localparam int TW = $clog2(TIMEOUT + 1);

    state_e         state_q, state_d;
    logic [TW-1:0]  tmo_q, tmo_d;
    logic [W-1:0]   core_x_q, core_x_d;
    logic [W-1:0]   core_y_q, core_y_d;
    logic           res_valid_q, res_valid_d;
    logic [PW-1:0]  res_prod_q, res_prod_d;
    logic           res_err_q, res_err_d;
    logic [7:0]     job_cnt_q, job_cnt_d;

    logic           start;
    logic           fifo_pop;
    logic [PW-1:0]  fifo_rdata;
    logic           fifo_full;
    logic           fifo_empty;
    logic           launch_ok;
    logic           tmo_hit;

    mult_job_fifo #(
        .DW    (PW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (bus.in_valid),
        .wdata_i ({bus.in_x, bus.in_y}),
        .pop_i   (fifo_pop),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // A new job may only start once the previous result has been taken and the core is idle.
    assign launch_ok = !fifo_empty && !res_valid_q && bus.done;
    assign tmo_hit   = (tmo_q == TW'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            tmo_q       <= '0;
            core_x_q    <= '0;
            core_y_q    <= '0;
            res_valid_q <= 1'b0;
            res_prod_q  <= '0;
            res_err_q   <= 1'b0;
            job_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            tmo_q       <= tmo_d;
            core_x_q    <= core_x_d;
            core_y_q    <= core_y_d;
            res_valid_q <= res_valid_d;
            res_prod_q  <= res_prod_d;
            res_err_q   <= res_err_d;
            job_cnt_q   <= job_cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (launch_ok) state_d = ST_LAUNCH;
            ST_LAUNCH: state_d = ST_ACKW;
            ST_ACKW: begin
                if (!bus.done)   state_d = ST_RUNW;
                else if (tmo_hit) state_d = ST_RESP;
            end
            ST_RUNW:   if (bus.done || tmo_hit) state_d = ST_RESP;
            ST_RESP:   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        tmo_d       = tmo_q;
        core_x_d    = core_x_q;
        core_y_d    = core_y_q;
        res_valid_d = res_valid_q;
        res_prod_d  = res_prod_q;
        res_err_d   = res_err_q;
        job_cnt_d   = job_cnt_q;
        start       = 1'b0;
        fifo_pop    = 1'b0;

        if (res_valid_q && bus.res_ready) res_valid_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (launch_ok) begin
                    fifo_pop = 1'b1;
                    core_x_d = fifo_rdata[PW-1:W];
                    core_y_d = fifo_rdata[W-1:0];
                end
            end
            ST_LAUNCH: begin
                start = 1'b1;
                tmo_d = '0;
            end
            ST_ACKW: begin
                if (!bus.done) begin
                    tmo_d = '0;
                end else if (tmo_hit) begin
                    res_prod_d  = '0;
                    res_err_d   = 1'b1;
                    res_valid_d = 1'b1;
                    job_cnt_d   = job_cnt_q + 8'd1;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            ST_RUNW: begin
                if (bus.done) begin
                    res_prod_d  = {bus.core_hi, bus.core_lo};
                    res_err_d   = 1'b0;
                    res_valid_d = 1'b1;
                    job_cnt_d   = job_cnt_q + 8'd1;
                end else if (tmo_hit) begin
                    res_prod_d  = '0;
                    res_err_d   = 1'b1;
                    res_valid_d = 1'b1;
                    job_cnt_d   = job_cnt_q + 8'd1;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            default: ;
        endcase
    end

    assign bus.in_ready  = !fifo_full;
    assign bus.start     = start;
    assign bus.core_x    = core_x_q;
    assign bus.core_y    = core_y_q;
    assign bus.res_valid = res_valid_q;
    assign bus.res_prod  = res_prod_q;
    assign bus.res_err   = res_err_q;
    assign bus.job_count = job_cnt_q;
    assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_mult_job_sequencer.sv
// Directed bench for mult_job_sequencer with a behavioural Booth core model and a result scoreboard.
// Inputs change 1 time unit after a rising edge; the linear flow samples there, the scoreboard on falling edges.
module tb_mult_job_sequencer;
    import mult_job_sequencer_pkg::*;

    localparam int W        = 8;
    localparam int TMO      = 64;
    localparam int CORE_LAT = 6;

    logic clk      = 1'b0;
    logic rst      = 1'b1;
    logic core_rst = 1'b1;
    logic hang     = 1'b0;
    state_e dbg_state;

    int tests_run    = 0;
    int tests_failed = 0;
    int start_cnt    = 0;

    int                busy = 0;
    logic signed [15:0] prod_m;
    logic [16:0]       exp_q[$];
    logic [16:0]       exp_m;

    mult_job_sequencer_if #(.W(W)) bus ();

    mult_job_sequencer #(
        .W       (W),
        .DEPTH   (2),
        .TIMEOUT (TMO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .dbg_state_o (dbg_state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic bound_fail(input string tag, input int n);
        tests_run++;
        tests_failed++;
        $error("FAIL %s: observed timeout after %0d cycles, expected event", tag, n);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] x, input logic [7:0] y);
        int n = 0;
        bus.in_valid = 1'b1;
        bus.in_x     = x;
        bus.in_y     = y;
        while (!bus.in_ready && n < 300) begin
            step();
            n++;
        end
        if (!bus.in_ready) bound_fail("push_in_ready", n);
        step();
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_start(input string tag);
        int n = 0;
        while (!bus.start && n < 300) begin
            step();
            n++;
        end
        if (!bus.start) bound_fail(tag, n);
    endtask

    task automatic wait_drain(input string tag, input int limit);
        int n = 0;
        while (exp_q.size() != 0 && n < limit) begin
            step();
            n++;
        end
        if (exp_q.size() != 0) bound_fail(tag, n);
    endtask

    // Behavioural core: done drops the cycle after start, stays low CORE_LAT cycles, then shows the product.
    always @(posedge clk) begin
        if (core_rst) begin
            bus.done    <= 1'b1;
            bus.core_hi <= '0;
            bus.core_lo <= '0;
            busy        <= 0;
        end else if (bus.start && !hang) begin
            bus.done <= 1'b0;
            busy     <= CORE_LAT;
            prod_m   <= $signed(bus.core_x) * $signed(bus.core_y);
        end else if (busy > 0) begin
            busy <= busy - 1;
            if (busy == 1) begin
                bus.done    <= 1'b1;
                bus.core_hi <= prod_m[15:8];
                bus.core_lo <= prod_m[7:0];
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (bus.start) begin
                start_cnt++;
                check("start_while_res_valid", bus.res_valid, 0);
            end
            if (bus.res_valid && bus.res_ready) begin
                if (exp_q.size() == 0) begin
                    tests_run++;
                    tests_failed++;
                    $error("FAIL unexpected_result: observed %0h, expected no result", {bus.res_err, bus.res_prod});
                end else begin
                    exp_m = exp_q.pop_front();
                    check("result", {15'd0, bus.res_err, bus.res_prod}, {15'd0, exp_m});
                end
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: observed simulation still running, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        int base;
        bus.in_valid  = 1'b0;
        bus.in_x      = '0;
        bus.in_y      = '0;
        bus.res_ready = 1'b1;

        // Reset state
        repeat (3) step();
        check("rst_res_valid", bus.res_valid, 0);
        check("rst_in_ready", bus.in_ready, 1);
        check("rst_start", bus.start, 0);
        check("rst_job_count", bus.job_count, 0);
        check("rst_res_prod", bus.res_prod, 0);
        check("rst_res_err", bus.res_err, 0);
        check("rst_core_x", bus.core_x, 0);
        check("rst_core_y", bus.core_y, 0);
        check("rst_state", dbg_state, ST_IDLE);
        rst      = 1'b0;
        core_rst = 1'b0;
        step();

        // Test 1: 5 * 3, start two cycles after the push, result L+2 cycles after start
        exp_q.push_back({1'b0, 16'h000F});
        bus.in_valid = 1'b1;
        bus.in_x     = 8'd5;
        bus.in_y     = 8'd3;
        step();
        bus.in_valid = 1'b0;
        check("t1_no_start_c1", bus.start, 0);
        step();
        check("t1_start_c2", bus.start, 1);
        check("t1_core_x", bus.core_x, 8'd5);
        check("t1_core_y", bus.core_y, 8'd3);
        n = 0;
        while (!bus.res_valid && n < 200) begin
            step();
            n++;
        end
        check("t1_latency", n, CORE_LAT + 2);
        check("t1_res_prod", bus.res_prod, 16'h000F);
        check("t1_res_err", bus.res_err, 0);
        check("t1_job_count", bus.job_count, 1);
        step();
        check("t1_res_cleared", bus.res_valid, 0);

        // Test 2: -3 * 7, operands held from LAUNCH to RESP
        exp_q.push_back({1'b0, 16'hFFEB});
        push(8'hFD, 8'h07);
        wait_start("t2_start");
        n = 0;
        while (!bus.res_valid && n < 200) begin
            check("t2_core_x_hold", bus.core_x, 8'hFD);
            step();
            n++;
        end
        check("t2_core_x_resp", bus.core_x, 8'hFD);
        check("t2_core_y_resp", bus.core_y, 8'h07);
        check("t2_res_prod", bus.res_prod, 16'hFFEB);
        check("t2_res_err", bus.res_err, 0);
        check("t2_job_count", bus.job_count, 2);
        step();

        // Test 3: back-pressure, FIFO fills, full FIFO ignores a fourth pair
        bus.res_ready = 1'b0;
        base = start_cnt;
        exp_q.push_back({1'b0, 16'd2});
        exp_q.push_back({1'b0, 16'd12});
        exp_q.push_back({1'b0, 16'd30});
        push(8'd1, 8'd2);
        push(8'd3, 8'd4);
        push(8'd5, 8'd6);
        check("t3_full_in_ready", bus.in_ready, 0);
        bus.in_valid = 1'b1;
        bus.in_x     = 8'd7;
        bus.in_y     = 8'd8;
        repeat (40) step();
        check("t3_still_full", bus.in_ready, 0);
        bus.in_valid = 1'b0;
        check("t3_one_launch", start_cnt - base, 1);
        check("t3_res_held", bus.res_valid, 1);
        check("t3_res_held_prod", bus.res_prod, 16'd2);
        bus.res_ready = 1'b1;
        wait_drain("t3_drain", 300);
        repeat (20) step();
        check("t3_three_launches", start_cnt - base, 3);
        check("t3_job_count", bus.job_count, 5);
        check("t3_in_ready", bus.in_ready, 1);

        // Test 4: core never acknowledges, abort TIMEOUT cycles into ACKW, next job runs normally
        exp_q.push_back({1'b1, 16'h0000});
        exp_q.push_back({1'b0, 16'h005A});
        hang = 1'b1;
        push(8'd4, 8'd4);
        push(8'd9, 8'd10);
        wait_start("t4_start");
        step();
        hang = 1'b0;
        check("t4_in_ackw", dbg_state, ST_ACKW);
        n = 0;
        while (!bus.res_valid && n < 300) begin
            step();
            n++;
        end
        check("t4_timeout_cycles", n, TMO);
        check("t4_res_err", bus.res_err, 1);
        check("t4_res_prod", bus.res_prod, 0);
        check("t4_state_resp", dbg_state, ST_RESP);
        wait_drain("t4_drain", 300);
        step();
        check("t4_job_count", bus.job_count, 7);

        // Test 5: reset while RUNW with two jobs queued
        push(8'd2, 8'd3);
        push(8'd4, 8'd5);
        push(8'd6, 8'd7);
        n = 0;
        while (dbg_state != ST_RUNW && n < 100) begin
            step();
            n++;
        end
        check("t5_in_runw", dbg_state, ST_RUNW);
        check("t5_queue_full", bus.in_ready, 0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("t5_res_valid", bus.res_valid, 0);
        check("t5_in_ready", bus.in_ready, 1);
        check("t5_job_count", bus.job_count, 0);
        check("t5_start", bus.start, 0);
        check("t5_state", dbg_state, ST_IDLE);
        check("t5_res_prod", bus.res_prod, 0);
        check("t5_core_x", bus.core_x, 0);
        base = start_cnt;
        n = 0;
        while (!bus.done && n < 50) begin
            step();
            n++;
        end
        repeat (10) step();
        check("t5_no_late_capture", bus.res_valid, 0);
        check("t5_job_count_late", bus.job_count, 0);
        check("t5_no_launch", start_cnt - base, 0);

        // Test 6: 256 zero jobs, job_count wraps
        for (int i = 0; i < 255; i++) begin
            exp_q.push_back(17'd0);
            push(8'd0, 8'd0);
        end
        wait_drain("t6_drain255", 5000);
        step();
        check("t6_job_count_255", bus.job_count, 255);
        exp_q.push_back(17'd0);
        push(8'd0, 8'd0);
        wait_drain("t6_drain256", 300);
        step();
        check("t6_job_count_wrap", bus.job_count, 0);

        repeat (5) step();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
